// File: rtl/core_mem_pkg.sv
// rtl/core_mem_pkg.sv - shared types and defaults for the core data-memory arbiter
package core_mem_pkg;

  localparam int DEF_NCORES    = 4;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_MAX_BURST = 4;
  localparam int SEL_W         = $clog2(DEF_NCORES);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arbStateT;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin priority picker
module rr_picker #(
  parameter int NCORES = 4
) (
  input  logic [NCORES-1:0]         req,
  input  logic [$clog2(NCORES)-1:0] rrPtr,
  output logic [$clog2(NCORES)-1:0] winner,
  output logic                      anyReq
);

  localparam int selW = $clog2(NCORES);

  int idx;

  // First set request bit at or after rrPtr, wrapping modulo NCORES
  always_comb begin
    winner = '0;
    anyReq = 1'b0;
    idx    = 0;
    for (int k = 0; k < NCORES; k++) begin
      idx = (int'(rrPtr) + k) % NCORES;
      if (!anyReq && req[idx]) begin
        anyReq = 1'b1;
        winner = selW'(idx);
      end
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - round-robin burst arbiter for the shared data-memory port
module core_mem_arbiter
  import core_mem_pkg::*;
#(
  parameter int NCORES    = DEF_NCORES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NCORES-1:0]          req,
  input  logic [NCORES-1:0]          we,
  input  logic [NCORES-1:0]          last,
  input  logic [NCORES*ADDR_W-1:0]   addr,
  input  logic [NCORES*DATA_W-1:0]   wdata,
  output logic [NCORES-1:0]          gnt,
  output logic [NCORES-1:0]          ack,
  output logic [NCORES-1:0]          rvalid,
  output logic [DATA_W-1:0]          rdata,
  output logic [$clog2(NCORES)-1:0]  sel,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata
);

  localparam int selW = $clog2(NCORES);
  localparam int cntW = $clog2(MAX_BURST + 1);

  arbStateT          state;
  arbStateT          nextState;
  logic [selW-1:0]   rrPtr;
  logic [cntW-1:0]   burstCnt;
  logic [selW-1:0]   winner;
  logic              anyReq;
  logic              releaseNow;

  rr_picker #(.NCORES(NCORES)) picker (
    .req    (req),
    .rrPtr  (rrPtr),
    .winner (winner),
    .anyReq (anyReq)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next state: arbitrate in IDLE, hold the grant until release
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (anyReq)     nextState = BUSY;
      BUSY:    if (releaseNow) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Port mux, handshake and release decode; rst_n gates the strobe so a write in the reset cycle never lands
  always_comb begin
    mem_en     = (state == BUSY) && req[sel] && rst_n;
    mem_we     = mem_en && we[sel];
    mem_addr   = addr[sel*ADDR_W +: ADDR_W];
    mem_wdata  = wdata[sel*DATA_W +: DATA_W];
    gnt        = (state == BUSY) ? (NCORES'(1) << sel) : '0;
    ack        = mem_en ? (NCORES'(1) << sel) : '0;
    rdata      = (|rvalid) ? mem_rdata : '0;
    releaseNow = (state == BUSY) &&
                 (!req[sel] ||
                  (mem_en && (last[sel] || burstCnt == cntW'(MAX_BURST - 1))));
  end

  // Owner, round-robin pointer, burst length and read-return tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel      <= '0;
      rrPtr    <= '0;
      burstCnt <= '0;
      rvalid   <= '0;
    end else begin
      rvalid <= '0;
      if (mem_en && !mem_we) rvalid[sel] <= 1'b1;
      if (state == IDLE) begin
        if (anyReq) begin
          sel      <= winner;
          burstCnt <= '0;
        end
      end else begin
        if (mem_en) burstCnt <= burstCnt + 1'b1;
        if (releaseNow) rrPtr <= (sel == selW'(NCORES - 1)) ? '0 : sel + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - directed self-checking bench for core_mem_arbiter
module tb_core_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    req, we, last;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, ack, rvalid;
  logic [DW-1:0]   rdata;
  logic [1:0]      sel;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   memRdata;

  core_mem_arbiter #(.NCORES(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .last(last), .addr(addr),
    .wdata(wdata), .gnt(gnt), .ack(ack), .rvalid(rvalid), .rdata(rdata),
    .sel(sel), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(memRdata)
  );

  // synchronous RAM with one-cycle read latency
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (mem_en && mem_we)  ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) memRdata <= ram[mem_addr];
  end

  // per-core stimulus source: a run of words, advanced on each ack
  int            remain [N];
  int            widx   [N];
  logic [AW-1:0] cAddr  [N];
  logic          cWe    [N];
  logic          cLast  [N];
  logic [DW-1:0] wtab   [N][8];

  logic [N-1:0]  sGnt, sAck, sRv;
  logic [DW-1:0] sRd, sWd;
  logic [AW-1:0] sAddr;
  logic [1:0]    sSel;
  logic          sEn, sWe;

  int nTests = 0;
  int nFail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]            = remain[i] > 0;
      we[i]             = cWe[i];
      last[i]           = cLast[i] && (remain[i] == 1);
      addr[i*AW +: AW]  = cAddr[i];
      wdata[i*DW +: DW] = wtab[i][widx[i] % 8];
    end
  endtask

  task automatic setCore(input int i, input int n, input logic w, input logic l, input logic [AW-1:0] a);
    remain[i] = n;
    widx[i]   = 0;
    cWe[i]    = w;
    cLast[i]  = l;
    cAddr[i]  = a;
  endtask

  // sample the current cycle at negedge, then advance sources after the edge
  task automatic tick();
    @(negedge clk);
    sGnt = gnt; sAck = ack; sRv = rvalid; sRd = rdata; sSel = sel;
    sEn = mem_en; sWe = mem_we; sAddr = mem_addr; sWd = mem_wdata;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (sAck[i]) begin
        remain[i]--;
        widx[i]++;
        cAddr[i] = cAddr[i] + 1'b1;
      end
    end
    drive();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) setCore(i, 0, 1'b0, 1'b0, '0);
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) ram[a] = '0;
    ram[8'h05] = 16'h00A5;
    ram[8'h06] = 16'h00A6;
    memRdata = '0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++) wtab[i][k] = 16'((i << 12) | k);
    wtab[0][0] = 16'h1234;
    wtab[0][1] = 16'hBEEF;

    // reset state
    doReset();
    tick();
    check("rst_gnt", 32'(sGnt), 32'h0);
    check("rst_rvalid", 32'(sRv), 32'h0);
    check("rst_rdata", 32'(sRd), 32'h0);
    check("rst_sel", 32'(sSel), 32'h0);
    check("rst_mem_en", 32'(sEn), 32'h0);

    // core0 writes two words, last on the second
    setCore(0, 2, 1'b1, 1'b1, 8'h10); drive();
    tick(); check("t1_c1_gnt", 32'(sGnt), 32'h0);
    tick(); check("t1_c2_gnt", 32'(sGnt), 32'h1);
            check("t1_c2_ack", 32'(sAck), 32'h1);
            check("t1_c2_we", 32'(sWe), 32'h1);
            check("t1_c2_addr", 32'(sAddr), 32'h10);
            check("t1_c2_wdata", 32'(sWd), 32'h1234);
    tick(); check("t1_c3_ack", 32'(sAck), 32'h1);
            check("t1_c3_addr", 32'(sAddr), 32'h11);
            check("t1_c3_wdata", 32'(sWd), 32'hBEEF);
    tick(); check("t1_c4_gnt", 32'(sGnt), 32'h0);
    check("t1_ram10", 32'(ram[8'h10]), 32'h1234);
    check("t1_ram11", 32'(ram[8'h11]), 32'hBEEF);

    // all four request one word each: 0,1,2,3 with an idle bubble between
    doReset();
    for (int i = 0; i < N; i++) setCore(i, 1, 1'b1, 1'b1, 8'h40 + 8'(i));
    drive();
    tick(); check("t2_c1_gnt", 32'(sGnt), 32'h0);
    tick(); check("t2_c2_gnt", 32'(sGnt), 32'h1);
    tick(); check("t2_c3_gnt", 32'(sGnt), 32'h0);
    tick(); check("t2_c4_gnt", 32'(sGnt), 32'h2);
    tick(); check("t2_c5_gnt", 32'(sGnt), 32'h0);
    tick(); check("t2_c6_gnt", 32'(sGnt), 32'h4);
    tick(); check("t2_c7_gnt", 32'(sGnt), 32'h0);
    tick(); check("t2_c8_gnt", 32'(sGnt), 32'h8);
            check("t2_c8_sel", 32'(sSel), 32'h3);
    setCore(0, 1, 1'b1, 1'b1, 8'h50);
    setCore(2, 1, 1'b1, 1'b1, 8'h52);
    drive();
    tick(); check("t2_c9_gnt", 32'(sGnt), 32'h0);
    tick(); check("t2_c10_gnt", 32'(sGnt), 32'h1);
    tick(); tick(); check("t2_c12_gnt", 32'(sGnt), 32'h4);

    // core2 single read of 0x05
    doReset();
    setCore(2, 1, 1'b0, 1'b1, 8'h05); drive();
    tick();
    tick(); check("t3_c2_ack", 32'(sAck), 32'h4);
            check("t3_c2_we", 32'(sWe), 32'h0);
            check("t3_c2_addr", 32'(sAddr), 32'h05);
            check("t3_c2_rvalid", 32'(sRv), 32'h0);
    tick(); check("t3_c3_rvalid", 32'(sRv), 32'h4);
            check("t3_c3_rdata", 32'(sRd), 32'h00A5);
            check("t3_c3_gnt", 32'(sGnt), 32'h0);
    tick(); check("t3_c4_rvalid", 32'(sRv), 32'h0);

    // core1 streams 6 words without last, core3 waits: forced release after 4
    doReset();
    setCore(1, 6, 1'b1, 1'b0, 8'h20);
    setCore(3, 1, 1'b1, 1'b1, 8'h30);
    drive();
    tick();
    tick(); check("t4_c2_ack", 32'(sAck), 32'h2);
    tick(); tick();
    tick(); check("t4_c5_ack", 32'(sAck), 32'h2);
            check("t4_c5_addr", 32'(sAddr), 32'h23);
    tick(); check("t4_c6_gnt", 32'(sGnt), 32'h0);
    tick(); check("t4_c7_gnt", 32'(sGnt), 32'h8);
            check("t4_c7_ack", 32'(sAck), 32'h8);
    tick(); check("t4_c8_gnt", 32'(sGnt), 32'h0);
    tick(); check("t4_c9_gnt", 32'(sGnt), 32'h2);
            check("t4_c9_addr", 32'(sAddr), 32'h24);
    tick(); check("t4_c10_addr", 32'(sAddr), 32'h25);
            check("t4_c10_ack", 32'(sAck), 32'h2);
    tick(); check("t4_c11_gnt", 32'(sGnt), 32'h2);
            check("t4_c11_mem_en", 32'(sEn), 32'h0);
    tick(); check("t4_c12_gnt", 32'(sGnt), 32'h0);
    check("t4_ram25", 32'(ram[8'h25]), 32'h1005);
    check("t4_ram30", 32'(ram[8'h30]), 32'h3000);

    // core0 abandons after one word, core2 waiting
    doReset();
    setCore(0, 1, 1'b1, 1'b0, 8'h60);
    setCore(2, 1, 1'b1, 1'b1, 8'h62);
    drive();
    tick();
    tick(); check("t5_c2_ack", 32'(sAck), 32'h1);
    tick(); check("t5_c3_gnt", 32'(sGnt), 32'h1);
            check("t5_c3_mem_en", 32'(sEn), 32'h0);
    tick(); check("t5_c4_gnt", 32'(sGnt), 32'h0);
            check("t5_c4_mem_en", 32'(sEn), 32'h0);
    tick(); check("t5_c5_gnt", 32'(sGnt), 32'h4);

    // reset in the middle of a core3 read burst
    doReset();
    setCore(3, 3, 1'b0, 1'b1, 8'h05); drive();
    tick();
    tick(); check("t6_c2_ack", 32'(sAck), 32'h8);
    rst_n = 1'b0;
    tick(); check("t6_c3_mem_en", 32'(sEn), 32'h0);
            check("t6_c3_ack", 32'(sAck), 32'h0);
    rst_n = 1'b1;
    setCore(1, 1, 1'b1, 1'b1, 8'h70);
    drive();
    tick(); check("t6_c4_gnt", 32'(sGnt), 32'h0);
            check("t6_c4_rvalid", 32'(sRv), 32'h0);
            check("t6_c4_mem_en", 32'(sEn), 32'h0);
    tick(); check("t6_c5_gnt", 32'(sGnt), 32'h2);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
